// File: rtl/lm_sm_uop_sequencer_if.sv
// Bundle of decode-side request, RR-side micro-op and status signals for
// the LM/SM micro-op sequencer.
// The "master" modport is the decode/RR environment; the "slave" modport is
// the sequencer itself.
// Optional feature macro: LMSM_PERF_CNT_EN adds the perf_uops/perf_stall counters.
interface lm_sm_uop_sequencer_if #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 16
);
    // Request from decode
    logic            start;
    logic            is_store;
    logic [AW-1:0]   base_reg;
    logic [NREG-1:0] reg_mask;
    logic            flush;
    // Handshake from register-read
    logic            uop_ready;
    // Micro-op towards register-read
    logic            uop_valid;
    logic            uop_store;
    logic [AW-1:0]   uop_reg;
    logic [AW-1:0]   uop_base;
    logic [DW-1:0]   uop_offset;
    logic            uop_last;
    logic            uop_r7_write;
    // Pipeline control / status
    logic            stall_fetch;
    logic            busy;
    logic            done;
`ifdef LMSM_PERF_CNT_EN
    logic [31:0]     perf_uops;
    logic [31:0]     perf_stall;

    modport master (
        output start, is_store, base_reg, reg_mask, flush, uop_ready,
        input  uop_valid, uop_store, uop_reg, uop_base, uop_offset, uop_last,
               uop_r7_write, stall_fetch, busy, done, perf_uops, perf_stall
    );
    modport slave (
        input  start, is_store, base_reg, reg_mask, flush, uop_ready,
        output uop_valid, uop_store, uop_reg, uop_base, uop_offset, uop_last,
               uop_r7_write, stall_fetch, busy, done, perf_uops, perf_stall
    );
`else
    modport master (
        output start, is_store, base_reg, reg_mask, flush, uop_ready,
        input  uop_valid, uop_store, uop_reg, uop_base, uop_offset, uop_last,
               uop_r7_write, stall_fetch, busy, done
    );
    modport slave (
        input  start, is_store, base_reg, reg_mask, flush, uop_ready,
        output uop_valid, uop_store, uop_reg, uop_base, uop_offset, uop_last,
               uop_r7_write, stall_fetch, busy, done
    );
`endif
endinterface

// File: rtl/lm_sm_uop_sequencer.sv
// Load-multiple / store-multiple micro-op sequencer.
// Expands one LM/SM register mask into one single-register micro-op per set
// bit, at most one per cycle, while holding fetch/decode. Honours RR
// backpressure (uop_ready) and pipeline flush.
// Optional feature macro: LMSM_PERF_CNT_EN adds saturating 32-bit counters of
// fired micro-ops (perf_uops) and backpressured cycles (perf_stall).
module lm_sm_uop_sequencer #(
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int DW      = 16,
    parameter int DESCEND = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lm_sm_uop_sequencer_if.slave    bus
);
    // Sequence counter only needs to count up to NREG micro-ops.
    localparam int CW = $clog2(NREG + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NREG-1:0] mask_q, mask_d;     // registers still to be issued
    logic [AW-1:0]   base_q, base_d;
    logic            store_q, store_d;
    logic [CW-1:0]   offset_q, offset_d;
    logic            done_q, done_d;

    logic            in_issue;
    logic [AW-1:0]   sel;
    logic            one_left;
    logic            fire;
    logic            last;

    // Priority encoder over the remaining mask: lowest set bit first, or the
    // highest one when DESCEND is set. Later loop iterations win.
    function automatic logic [AW-1:0] pick(input logic [NREG-1:0] m);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            int j;
            j = (DESCEND != 0) ? i : (NREG - 1 - i);
            if (m[j]) r = AW'(j);
        end
        return r;
    endfunction

    assign in_issue = (state_q == ISSUE);
    assign sel      = pick(mask_q);
    assign one_left = (mask_q != '0) && ((mask_q & (mask_q - NREG'(1))) == '0);
    assign fire     = in_issue && bus.uop_ready;
    assign last     = in_issue && one_left;

    // Next-state decode; flush outranks everything, start is only heard in IDLE.
    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path leaves it
        // unassigned, which is what would otherwise infer a latch.
        state_d  = state_q;
        mask_d   = mask_q;
        base_d   = base_q;
        store_d  = store_q;
        offset_d = offset_q;
        done_d   = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            mask_d  = '0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                if (bus.reg_mask != '0) begin
                    state_d  = ISSUE;
                    mask_d   = bus.reg_mask;
                    base_d   = bus.base_reg;
                    store_d  = bus.is_store;
                    offset_d = '0;
                end else begin
                    // Empty register list: nothing to issue, just acknowledge.
                    done_d = 1'b1;
                end
            end
        end else if (fire) begin
            mask_d[sel] = 1'b0;
            offset_d    = offset_q + CW'(1);
            if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            base_q   <= '0;
            store_q  <= 1'b0;
            offset_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state_q  <= state_d;
            mask_q   <= mask_d;
            base_q   <= base_d;
            store_q  <= store_d;
            offset_q <= offset_d;
            done_q   <= done_d;
        end
    end

    // Micro-op outputs come straight from the state registers, so they are
    // stable for as long as RR withholds uop_ready.
    assign bus.uop_valid    = in_issue;
    assign bus.uop_store    = store_q;
    assign bus.uop_reg      = sel;
    assign bus.uop_base     = base_q;
    assign bus.uop_offset   = DW'(offset_q);
    assign bus.uop_last     = last;
    assign bus.uop_r7_write = in_issue && !store_q && (sel == AW'(NREG - 1));
    assign bus.busy         = in_issue;
    assign bus.done         = done_q;

    // Keep the LM/SM instruction in IF/ID from its start cycle until the edge
    // on which its last micro-op is accepted; a flush releases it at once.
    assign bus.stall_fetch  = in_issue ? (!(fire && last) && !bus.flush)
                                       : (bus.start && (bus.reg_mask != '0) && !bus.flush);

`ifdef LMSM_PERF_CNT_EN
    logic [31:0] perf_uops_q, perf_uops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating event counters; flush does not touch them.
    always_comb begin
        perf_uops_d  = perf_uops_q;
        perf_stall_d = perf_stall_q;
        if (fire && (perf_uops_q != '1)) perf_uops_d = perf_uops_q + 32'd1;
        if (in_issue && !bus.uop_ready && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_uops_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_uops_q  <= perf_uops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.perf_uops  = perf_uops_q;
    assign bus.perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_lm_sm_uop_sequencer.sv
// Self-checking bench for lm_sm_uop_sequencer. Three instances share one
// stimulus stream: NREG=8 ascending, NREG=8 descending, NREG=16 ascending.
// Each is compared every cycle against a queue-based model of the pending
// micro-op list.
module tb_lm_sm_uop_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [3:0]  base;
    logic [15:0] mask;
    logic        flush;
    logic        ready;

    int n_total;
    int n_bad;

    lm_sm_uop_sequencer_if #(.NREG(8),  .AW(3), .DW(16)) if_a ();
    lm_sm_uop_sequencer_if #(.NREG(8),  .AW(3), .DW(16)) if_d ();
    lm_sm_uop_sequencer_if #(.NREG(16), .AW(4), .DW(16)) if_w ();

    lm_sm_uop_sequencer #(.NREG(8),  .AW(3), .DW(16), .DESCEND(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    lm_sm_uop_sequencer #(.NREG(8),  .AW(3), .DW(16), .DESCEND(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
    lm_sm_uop_sequencer #(.NREG(16), .AW(4), .DW(16), .DESCEND(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    assign if_a.start = start;  assign if_a.is_store = is_store;  assign if_a.base_reg = base[2:0];
    assign if_a.reg_mask = mask[7:0];  assign if_a.flush = flush;  assign if_a.uop_ready = ready;
    assign if_d.start = start;  assign if_d.is_store = is_store;  assign if_d.base_reg = base[2:0];
    assign if_d.reg_mask = mask[7:0];  assign if_d.flush = flush;  assign if_d.uop_ready = ready;
    assign if_w.start = start;  assign if_w.is_store = is_store;  assign if_w.base_reg = base;
    assign if_w.reg_mask = mask;       assign if_w.flush = flush;  assign if_w.uop_ready = ready;

    typedef struct packed {
        logic        valid;
        logic        store;
        logic [3:0]  rg;
        logic [3:0]  base;
        logic [15:0] off;
        logic        last;
        logic        r7;
        logic        stall;
        logic        busy;
        logic        done;
    } obs_t;

    obs_t obs [3];

    assign obs[0] = {if_a.uop_valid, if_a.uop_store, 1'b0, if_a.uop_reg, 1'b0, if_a.uop_base, if_a.uop_offset,
                     if_a.uop_last, if_a.uop_r7_write, if_a.stall_fetch, if_a.busy, if_a.done};
    assign obs[1] = {if_d.uop_valid, if_d.uop_store, 1'b0, if_d.uop_reg, 1'b0, if_d.uop_base, if_d.uop_offset,
                     if_d.uop_last, if_d.uop_r7_write, if_d.stall_fetch, if_d.busy, if_d.done};
    assign obs[2] = {if_w.uop_valid, if_w.uop_store, if_w.uop_reg, if_w.uop_base, if_w.uop_offset,
                     if_w.uop_last, if_w.uop_r7_write, if_w.stall_fetch, if_w.busy, if_w.done};

`ifdef LMSM_PERF_CNT_EN
    logic [31:0] got_uops  [3];
    logic [31:0] got_stall [3];
    assign got_uops[0] = if_a.perf_uops;  assign got_stall[0] = if_a.perf_stall;
    assign got_uops[1] = if_d.perf_uops;  assign got_stall[1] = if_d.perf_stall;
    assign got_uops[2] = if_w.perf_uops;  assign got_stall[2] = if_w.perf_stall;
`endif

    // Reference model: list of registers still to issue, in issue order.
    int nreg [3] = '{8, 8, 16};
    bit desc [3] = '{1'b0, 1'b1, 1'b0};
    int mq [3][$];
    int m_off   [3];
    bit m_store [3];
    int m_base  [3];
    bit m_done  [3];
    int p_uops  [3];
    int p_stall [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_off[k]   = 0;
            m_store[k] = 1'b0;
            m_base[k]  = 0;
            m_done[k]  = 1'b0;
            p_uops[k]  = 0;
            p_stall[k] = 0;
        end
    endtask

    // Compare every instance against the model, then advance the model
    // across the coming clock edge.
    task automatic model_cycle();
        for (int k = 0; k < 3; k++) begin
            int n;
            bit v;
            int sel;
            bit lst;
            int meff;
            bit stl;
            n    = mq[k].size();
            v    = (n > 0);
            sel  = v ? mq[k][0] : 0;
            lst  = (n == 1);
            meff = int'(mask) & ((1 << nreg[k]) - 1);
            stl  = v ? (!(ready && lst) && !flush) : (start && (meff != 0) && !flush);
            check($sformatf("valid%0d", k), 32'(obs[k].valid), 32'(v));
            check($sformatf("busy%0d", k),  32'(obs[k].busy),  32'(v));
            check($sformatf("last%0d", k),  32'(obs[k].last),  32'(v && lst));
            check($sformatf("done%0d", k),  32'(obs[k].done),  32'(m_done[k]));
            check($sformatf("stall%0d", k), 32'(obs[k].stall), 32'(stl));
            if (v) begin
                check($sformatf("reg%0d", k),    32'(obs[k].rg),    32'(sel));
                check($sformatf("offset%0d", k), 32'(obs[k].off),   32'(m_off[k] & 16'hFFFF));
                check($sformatf("store%0d", k),  32'(obs[k].store), 32'(m_store[k]));
                check($sformatf("base%0d", k),   32'(obs[k].base),  32'(m_base[k]));
                check($sformatf("r7w%0d", k),    32'(obs[k].r7),    32'(!m_store[k] && (sel == nreg[k] - 1)));
            end
`ifdef LMSM_PERF_CNT_EN
            check($sformatf("perf_uops%0d", k),  got_uops[k],  32'(p_uops[k]));
            check($sformatf("perf_stall%0d", k), got_stall[k], 32'(p_stall[k]));
            if (v && ready) p_uops[k]++;
            if (v && !ready) p_stall[k]++;
`endif
            if (flush) begin
                mq[k].delete();
                m_done[k] = 1'b0;
            end else if (v) begin
                if (ready) begin
                    void'(mq[k].pop_front());
                    m_off[k]++;
                    m_done[k] = (mq[k].size() == 0);
                end else begin
                    m_done[k] = 1'b0;
                end
            end else if (start) begin
                if (meff != 0) begin
                    for (int i = 0; i < nreg[k]; i++) begin
                        int b;
                        b = desc[k] ? (nreg[k] - 1 - i) : i;
                        if (meff[b]) mq[k].push_back(b);
                    end
                    m_off[k]   = 0;
                    m_store[k] = is_store;
                    m_base[k]  = int'(base) & (nreg[k] - 1);
                    m_done[k]  = 1'b0;
                end else begin
                    m_done[k] = 1'b1;
                end
            end else begin
                m_done[k] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of stimulus, check at the falling edge, return at posedge+1.
    task automatic step(input bit s, input bit st, input int b, input int m, input bit f, input bit r);
        start    = s;
        is_store = st;
        base     = 4'(b);
        mask     = 16'(m);
        flush    = f;
        ready    = r;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, r);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s%0d", tag, k), 32'(obs[k]), 32'd0);
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        is_store = 1'b0;
        base     = '0;
        mask     = '0;
        flush    = 1'b0;
        ready    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LM, mask A5, base 3, RR always ready
        step(1'b1, 1'b0, 3, 16'h00A5, 1'b0, 1'b1);
        idle(6, 1'b1);

        // SM, mask 06
        step(1'b1, 1'b1, 2, 16'h0006, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Single register held off by RR for three cycles
        step(1'b1, 1'b0, 1, 16'h0040, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Empty register list
        step(1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Flush after two of four micro-ops, then a fresh start
        step(1'b1, 1'b0, 5, 16'h000F, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b1, 6, 16'h00F0, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b1, 1'b0, 4, 16'h000F, 1'b0, 1'b1);
        idle(6, 1'b1);

        // Start held high across a sequence: accepted again after the last fire
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2, 16'h0003, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Asynchronous reset mid-sequence
        step(1'b1, 1'b0, 7, 16'h8001, 1'b0, 1'b1);
        start = 1'b0;
        mask  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 7, 16'h8001, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            bit s, st, f, r;
            int m;
            s  = ($urandom_range(0, 2) == 0);
            st = 1'($urandom_range(0, 1));
            f  = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom & $urandom & 32'hFFFF);
            step(s, st, int'($urandom_range(0, 15)), m, f, r);
        end
        idle(20, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
